// File: rtl/ps2_key_sequencer_if.sv
// Signal bundle between the PS/2 receiver, the key sequencer and the game logic.
// The master side drives the receiver bytes and the consumer handshake.
interface ps2_key_sequencer_if;
   logic [7:0] ps2Code;
   logic       ps2Valid;
   logic       evtReady;
   logic       clrOverflow;
   logic       evtValid;
   logic [7:0] evtCode;
   logic       evtBreak;
   logic       evtExt;
   logic [4:0] keys;
   logic       overflow;

   modport master (
      output ps2Code, ps2Valid, evtReady, clrOverflow,
      input  evtValid, evtCode, evtBreak, evtExt, keys, overflow
   );

   modport slave (
      input  ps2Code, ps2Valid, evtReady, clrOverflow,
      output evtValid, evtCode, evtBreak, evtExt, keys, overflow
   );
endinterface

// File: rtl/ps2_key_sequencer.sv
// Turns the PS/2 byte stream into make/break key events (E0/F0 prefixes decoded),
// queues them in a small first-word-fall-through FIFO and tracks the held arcade controls.
module ps2_key_sequencer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   ps2_key_sequencer_if.slave    bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } state_t;

   // Codes that are never part of a key event (receiver/keyboard status bytes and E1).
   function automatic logic is_ignored(input logic [7:0] code);
      case (code)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1: is_ignored = 1'b1;
         default:                                       is_ignored = 1'b0;
      endcase
   endfunction

   // One-hot mask of the arcade control a completed event refers to, {fire,right,left,down,up}.
   function automatic logic [4:0] key_mask(input logic [7:0] code, input logic ext);
      key_mask = 5'b00000;
      if (ext) begin
         case (code)
            8'h75:   key_mask = 5'b00001;
            8'h72:   key_mask = 5'b00010;
            8'h6B:   key_mask = 5'b00100;
            8'h74:   key_mask = 5'b01000;
            default: key_mask = 5'b00000;
         endcase
      end else if (code == 8'h29) begin
         key_mask = 5'b10000;
      end else begin
         key_mask = 5'b00000;
      end
   endfunction

   state_t          state_r;
   state_t          next_state_s;
   logic [TW-1:0]   timer_r;
   logic            prev_valid_r;
   logic            byte_stb_s;
   logic            push_s;
   logic            push_brk_s;
   logic            push_ext_s;
   logic            timeout_s;

   logic [9:0]      mem_r [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            full_s;
   logic            pop_s;
   logic            wr_en_s;
   logic [4:0]      keys_r;
   logic            overflow_r;
   logic [4:0]      mask_s;

   assign byte_stb_s = bus.ps2Valid & ~prev_valid_r;
   assign timeout_s  = (state_r != IDLE) && (timer_r == TIMER_END);

   // Edge detector on the receiver valid level; starts high so a level held through reset is not a byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_valid_r <= 1'b1;
      end else begin
         prev_valid_r <= bus.ps2Valid;
      end
   end

   // Prefix decoder: chooses the next state and whether the current byte completes an event.
   always_comb begin
      next_state_s = state_r;
      push_s       = 1'b0;
      push_brk_s   = 1'b0;
      push_ext_s   = 1'b0;
      if (byte_stb_s) begin
         case (state_r)
            IDLE: begin
               if (bus.ps2Code == 8'hE0) begin
                  next_state_s = EXT;
               end else if (bus.ps2Code == 8'hF0) begin
                  next_state_s = BRK;
               end else if (is_ignored(bus.ps2Code)) begin
                  next_state_s = IDLE;
               end else begin
                  push_s = 1'b1;
               end
            end
            EXT: begin
               if (is_ignored(bus.ps2Code) || bus.ps2Code == 8'hE0) begin
                  next_state_s = IDLE;
               end else if (bus.ps2Code == 8'hF0) begin
                  next_state_s = EXT_BRK;
               end else begin
                  push_s       = 1'b1;
                  push_ext_s   = 1'b1;
                  next_state_s = IDLE;
               end
            end
            BRK: begin
               next_state_s = IDLE;
               if (is_ignored(bus.ps2Code) || bus.ps2Code == 8'hF0) begin
                  push_s = 1'b0;
               end else begin
                  push_s     = 1'b1;
                  push_brk_s = 1'b1;
               end
            end
            EXT_BRK: begin
               next_state_s = IDLE;
               if (is_ignored(bus.ps2Code) || bus.ps2Code == 8'hE0 || bus.ps2Code == 8'hF0) begin
                  push_s = 1'b0;
               end else begin
                  push_s     = 1'b1;
                  push_brk_s = 1'b1;
                  push_ext_s = 1'b1;
               end
            end
            default: next_state_s = IDLE;
         endcase
      end else if (timeout_s) begin
         next_state_s = IDLE;
      end else begin
         next_state_s = state_r;
      end
   end

   // Sequencer state and inter-byte timer; a byte in the timeout cycle takes precedence.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         timer_r <= '0;
      end else begin
         state_r <= next_state_s;
         if (byte_stb_s || state_r == IDLE || timeout_s) begin
            timer_r <= '0;
         end else begin
            timer_r <= timer_r + TW'(1);
         end
      end
   end

   assign full_s  = (count_r == DEPTH_C);
   assign pop_s   = (count_r != '0) & bus.evtReady;
   assign wr_en_s = push_s & (~full_s | pop_s);

   // Event FIFO; a pop in the same cycle makes room for a push into a full queue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 10'd0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {bus.ps2Code, push_brk_s, push_ext_s};
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({wr_en_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign mask_s = key_mask(bus.ps2Code, push_ext_s);

   // Held-control bitmap and sticky overflow flag; keys track events even when the FIFO drops them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         keys_r     <= 5'b00000;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            keys_r <= push_brk_s ? (keys_r & ~mask_s) : (keys_r | mask_s);
         end
         if (push_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
         end else if (bus.clrOverflow) begin
            overflow_r <= 1'b0;
         end
      end
   end

   assign bus.evtValid = (count_r != '0);
   assign bus.evtCode  = mem_r[rd_ptr_r][9:2];
   assign bus.evtBreak = mem_r[rd_ptr_r][1];
   assign bus.evtExt   = mem_r[rd_ptr_r][0];
   assign bus.keys     = keys_r;
   assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed self-checking bench for ps2_key_sequencer with a shortened timeout.
module tb_ps2_key_sequencer;
   localparam int TO = 64;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   ps2_key_sequencer_if bus_if ();

   ps2_key_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] code);
      @(negedge clk);
      bus_if.ps2Code  = code;
      bus_if.ps2Valid = 1'b1;
      @(negedge clk);
      bus_if.ps2Valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] code,
                             input logic brk, input logic ext);
      @(negedge clk);
      check_eq({tag, ".valid"}, {31'd0, bus_if.evtValid}, 32'd1);
      check_eq({tag, ".code"},  {24'd0, bus_if.evtCode},  {24'd0, code});
      check_eq({tag, ".brk"},   {31'd0, bus_if.evtBreak}, {31'd0, brk});
      check_eq({tag, ".ext"},   {31'd0, bus_if.evtExt},   {31'd0, ext});
      bus_if.evtReady = 1'b1;
      @(negedge clk);
      bus_if.evtReady = 1'b0;
   endtask

   task automatic expect_empty(input string tag);
      @(negedge clk);
      check_eq(tag, {31'd0, bus_if.evtValid}, 32'd0);
   endtask

   initial begin
      n_checks           = 0;
      n_fail             = 0;
      rst                = 1'b0;
      bus_if.ps2Code     = 8'h00;
      bus_if.ps2Valid    = 1'b0;
      bus_if.evtReady    = 1'b0;
      bus_if.clrOverflow = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst.valid",    {31'd0, bus_if.evtValid}, 32'd0);
      check_eq("rst.keys",     {27'd0, bus_if.keys},     32'd0);
      check_eq("rst.overflow", {31'd0, bus_if.overflow}, 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: long valid level yields one event with one-cycle latency
      bus_if.ps2Code  = 8'h1C;
      bus_if.ps2Valid = 1'b1;
      check_eq("t1.pre", {31'd0, bus_if.evtValid}, 32'd0);
      @(negedge clk);
      check_eq("t1.lat", {31'd0, bus_if.evtValid}, 32'd1);
      repeat (1000) @(negedge clk);
      bus_if.ps2Valid = 1'b0;
      pop_expect("t1.ev", 8'h1C, 1'b0, 1'b0);
      expect_empty("t1.one");

      // 2: extended make/break and fire key
      send_byte(8'hE0); send_byte(8'h75);
      check_eq("t2.up_set", {27'd0, bus_if.keys}, 32'h01);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      check_eq("t2.up_clr", {27'd0, bus_if.keys}, 32'h00);
      pop_expect("t2.mk", 8'h75, 1'b0, 1'b1);
      pop_expect("t2.bk", 8'h75, 1'b1, 1'b1);
      send_byte(8'h29);
      check_eq("t2.fire_set", {27'd0, bus_if.keys}, 32'h10);
      send_byte(8'hF0); send_byte(8'h29);
      check_eq("t2.fire_clr", {27'd0, bus_if.keys}, 32'h00);
      pop_expect("t2.fmk", 8'h29, 1'b0, 1'b0);
      pop_expect("t2.fbk", 8'h29, 1'b1, 1'b0);
      expect_empty("t2.empty");

      // 3: overflow, push+pop while full, clear
      send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
      check_eq("t3.no_ovf", {31'd0, bus_if.overflow}, 32'd0);
      send_byte(8'h2C);
      check_eq("t3.ovf", {31'd0, bus_if.overflow}, 32'd1);
      @(negedge clk);
      bus_if.ps2Code  = 8'h35;
      bus_if.ps2Valid = 1'b1;
      bus_if.evtReady = 1'b1;
      @(negedge clk);
      bus_if.ps2Valid = 1'b0;
      bus_if.evtReady = 1'b0;
      bus_if.clrOverflow = 1'b1;
      @(negedge clk);
      bus_if.clrOverflow = 1'b0;
      check_eq("t3.clr", {31'd0, bus_if.overflow}, 32'd0);
      pop_expect("t3.e1", 8'h1D, 1'b0, 1'b0);
      pop_expect("t3.e2", 8'h24, 1'b0, 1'b0);
      pop_expect("t3.e3", 8'h2D, 1'b0, 1'b0);
      pop_expect("t3.e4", 8'h35, 1'b0, 1'b0);
      expect_empty("t3.empty");

      // 4: prefix expires after the timeout, but not before it
      send_byte(8'hE0);
      repeat (TO + 8) @(negedge clk);
      send_byte(8'h1C);
      pop_expect("t4.to", 8'h1C, 1'b0, 1'b0);
      send_byte(8'hE0);
      repeat (TO / 2) @(negedge clk);
      send_byte(8'h74);
      pop_expect("t4.in", 8'h74, 1'b0, 1'b1);
      check_eq("t4.right", {27'd0, bus_if.keys}, 32'h08);

      // 5: aborts
      send_byte(8'hF0); send_byte(8'hAA);
      expect_empty("t5.abort");
      send_byte(8'h1C);
      pop_expect("t5.idle", 8'h1C, 1'b0, 1'b0);
      send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h75);
      pop_expect("t5.ee", 8'h75, 1'b0, 1'b0);
      expect_empty("t5.empty");

      // 6: valid high through reset, then reset mid-sequence
      bus_if.ps2Code  = 8'h1C;
      bus_if.ps2Valid = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("t6.no_ev", {31'd0, bus_if.evtValid}, 32'd0);
      check_eq("t6.keys0", {27'd0, bus_if.keys},     32'd0);
      bus_if.ps2Valid = 1'b0;
      send_byte(8'h29); send_byte(8'h1C); send_byte(8'hE0);
      check_eq("t6.pre_keys",  {27'd0, bus_if.keys},     32'h10);
      check_eq("t6.pre_valid", {31'd0, bus_if.evtValid}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check_eq("t6.rst_valid", {31'd0, bus_if.evtValid}, 32'd0);
      check_eq("t6.rst_keys",  {27'd0, bus_if.keys},     32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      send_byte(8'h75);
      pop_expect("t6.idle", 8'h75, 1'b0, 1'b0);
      expect_empty("t6.empty");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
